// File: rtl/load_store_unit.sv
// load_store_unit: initiator side of the data-memory load/store port.
// Takes one load/store from the core, issues one or two word-aligned
// memory beats with byte enables, merges and extends returned data and
// answers with a single-cycle response.
// Optional feature macro: LSU_MISALIGNED_SPLIT_EN. When it is defined, an
// access that crosses a word boundary runs as two beats. When it is not
// defined, such an access is answered with an error and no memory beat.
module load_store_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_ctrl,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic              mem_we,
  output logic [3:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

`ifdef LSU_MISALIGNED_SPLIT_EN
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;
`else
  typedef enum logic [2:0] {IDLE, REQ0, WAIT0, RESP} state_t;
`endif

  // Byte mask of the access size, LSB-justified (B=0001, H=0011, W=1111).
  function automatic logic [3:0] sizeMask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 4'b0001;
      2'b01:   return 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // True when the last byte of the access lands in the next word.
  function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
    logic [2:0] lastByte;
    case (sz)
      2'b00:   lastByte = {1'b0, off};
      2'b01:   lastByte = {1'b0, off} + 3'd1;
      default: lastByte = {1'b0, off} + 3'd3;
    endcase
    return lastByte[2];
  endfunction

  state_t            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata0_q, rdata0_d;
  logic              err_q, err_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
  logic [31:0]       rdata1_q, rdata1_d;
  logic [7:0]        laneBe;
  logic [63:0]       laneData;
`else
  logic [3:0]        laneBe;
  logic [31:0]       laneData;
`endif

  logic              reqIllegal;
  logic              reqErr;
  logic [1:0]        off;
  logic [3:0]        mask;
  logic [4:0]        byteShift;
  logic [ADDR_W-1:0] wordAddr0;
  logic [31:0]       aligned;
  logic [31:0]       loadData;

  // Encodings 011/110/111 are never legal; stores only support B/H/W.
  assign reqIllegal = (req_ctrl == 3'b011) | (req_ctrl[2] & req_ctrl[1]) | (req_we & req_ctrl[2]);
`ifdef LSU_MISALIGNED_SPLIT_EN
  assign reqErr = reqIllegal;
`else
  assign reqErr = reqIllegal | crosses(req_addr[1:0], req_ctrl[1:0]);
`endif

  assign off       = addr_q[1:0];
  assign mask      = sizeMask(ctrl_q[1:0]);
  assign byteShift = {off, 3'b000};
  assign wordAddr0 = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign laneBe   = {4'b0000, mask} << off;
  assign laneData = {32'h0, wdata_q} << byteShift;
  assign aligned  = 32'({rdata1_q, rdata0_q} >> byteShift);
`else
  assign laneBe   = mask << off;
  assign laneData = wdata_q << byteShift;
  assign aligned  = rdata0_q >> byteShift;
`endif

  // State and captured-request registers; reset abandons any beat in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      ctrl_q   <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      rdata0_q <= 32'h0;
      err_q    <= 1'b0;
`ifdef LSU_MISALIGNED_SPLIT_EN
      rdata1_q <= 32'h0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      ctrl_q   <= ctrl_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      err_q    <= err_d;
`ifdef LSU_MISALIGNED_SPLIT_EN
      rdata1_q <= rdata1_d;
`endif
    end
  end

  // Next-state logic: capture on accept, walk the beats, then one response cycle.
  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    ctrl_d   = ctrl_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    err_d    = err_q;
`ifdef LSU_MISALIGNED_SPLIT_EN
    rdata1_d = rdata1_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d     = req_we;
          ctrl_d   = req_ctrl;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rdata0_d = 32'h0;
          err_d    = reqErr;
`ifdef LSU_MISALIGNED_SPLIT_EN
          rdata1_d = 32'h0;
`endif
          state_d  = reqErr ? RESP : REQ0;
        end
      end
      REQ0: begin
        if (mem_gnt) state_d = WAIT0;
      end
      WAIT0: begin
        if (mem_rvalid) begin
          rdata0_d = mem_rdata;
`ifdef LSU_MISALIGNED_SPLIT_EN
          state_d  = crosses(off, ctrl_q[1:0]) ? REQ1 : RESP;
`else
          state_d  = RESP;
`endif
        end
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      REQ1: begin
        if (mem_gnt) state_d = WAIT1;
      end
      WAIT1: begin
        if (mem_rvalid) begin
          rdata1_d = mem_rdata;
          state_d  = RESP;
        end
      end
`endif
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Memory beat fields come straight from the captured request, so they stay put while gnt is low.
  always_comb begin
    mem_be    = 4'h0;
    mem_addr  = '0;
    mem_wdata = 32'h0;
    case (state_q)
      REQ0: begin
        mem_be    = laneBe[3:0];
        mem_addr  = wordAddr0;
        mem_wdata = laneData[31:0];
      end
`ifdef LSU_MISALIGNED_SPLIT_EN
      REQ1: begin
        mem_be    = laneBe[7:4];
        mem_addr  = wordAddr0 + ADDR_W'(4);
        mem_wdata = laneData[63:32];
      end
`endif
      default: begin
        mem_be    = 4'h0;
        mem_addr  = '0;
        mem_wdata = 32'h0;
      end
    endcase
  end

  // Sign- or zero-extend the byte-aligned load data according to the access type.
  always_comb begin
    case (ctrl_q)
      3'b000:  loadData = {{24{aligned[7]}}, aligned[7:0]};
      3'b001:  loadData = {{16{aligned[15]}}, aligned[15:0]};
      3'b100:  loadData = {24'h0, aligned[7:0]};
      3'b101:  loadData = {16'h0, aligned[15:0]};
      default: loadData = aligned;
    endcase
  end

`ifdef LSU_MISALIGNED_SPLIT_EN
  assign mem_req = (state_q == REQ0) | (state_q == REQ1);
`else
  assign mem_req = (state_q == REQ0);
`endif
  assign mem_we    = mem_req & we_q;
  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_err   = rsp_valid & err_q;
  assign rsp_rdata = (rsp_valid & ~err_q & ~we_q) ? loadData : 32'h0;

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: self-checking bench for load_store_unit.
// A word-wide memory responder sits on the memory port; a byte-level
// reference memory predicts beats and load results. Honours the
// LSU_MISALIGNED_SPLIT_EN macro the same way the design does.
module tb_load_store_unit;

  localparam int ADDR_W = 32;
`ifdef LSU_MISALIGNED_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_ctrl = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  int checks = 0;
  int failures = 0;

  load_store_unit #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_ctrl(req_ctrl), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_be(mem_be),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Comparison primitive: every check in the bench goes through here.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // An expired wait bound counts as a failed comparison.
  task automatic timeoutFail(input string name);
    checks++;
    failures++;
    $display("[TB] FAIL %s timed out", name);
  endtask

  // ---------------- memory responder (word array) ----------------
  logic [31:0] wordMem [logic [31:0]];
  logic [31:0] logAddr[$];
  logic [3:0]  logBe[$];
  logic        logWe[$];
  logic [31:0] logWd[$];
  int          stallCnt = 0;
  bit          randomGnt = 1'b0;
  int          rvalidDelay = 1;
  int          pendingCnt = 0;
  logic [31:0] pendingData = 32'h0;
  bit          prevHeld = 1'b0;
  logic [31:0] heldAddr, heldWd;
  logic [3:0]  heldBe;
  logic        heldWe;

  function automatic logic [31:0] rdWord(input logic [31:0] a);
    if (wordMem.exists(a)) return wordMem[a];
    return 32'h0;
  endfunction

  // Memory side: decide gnt for the coming edge, perform granted beats, return rvalid later.
  always @(negedge clk) begin
    logic [31:0] w;
    mem_rvalid = 1'b0;
    if (pendingCnt > 0) begin
      pendingCnt--;
      if (pendingCnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = pendingData;
      end
    end
    if (mem_req) begin
      if (prevHeld) begin
        checkOutput("hold_addr", mem_addr, heldAddr);
        checkOutput("hold_be", 32'(mem_be), 32'(heldBe));
        checkOutput("hold_we", 32'(mem_we), 32'(heldWe));
        checkOutput("hold_wdata", mem_wdata, heldWd);
      end
      if (stallCnt > 0) begin
        stallCnt--;
        mem_gnt  = 1'b0;
        prevHeld = 1'b1;
        heldAddr = mem_addr;
        heldBe   = mem_be;
        heldWe   = mem_we;
        heldWd   = mem_wdata;
      end else begin
        mem_gnt  = 1'b1;
        prevHeld = 1'b0;
        logAddr.push_back(mem_addr);
        logBe.push_back(mem_be);
        logWe.push_back(mem_we);
        logWd.push_back(mem_wdata);
        w = rdWord(mem_addr);
        if (mem_we) begin
          for (int b = 0; b < 4; b++)
            if (mem_be[b]) w[8*b +: 8] = mem_wdata[8*b +: 8];
          wordMem[mem_addr] = w;
        end
        pendingData = w;
        pendingCnt  = rvalidDelay;
        if (randomGnt) stallCnt = $urandom_range(0, 2);
      end
    end else begin
      prevHeld = 1'b0;
      mem_gnt  = randomGnt ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // ---------------- byte-level reference model ----------------
  logic [7:0]  refMem [logic [31:0]];
  logic [31:0] expAddr [2];
  logic [3:0]  expBe [2];
  logic [31:0] expWd [2];
  int          expCount;

  function automatic logic [7:0] refByte(input logic [31:0] a);
    if (refMem.exists(a)) return refMem[a];
    return 8'h00;
  endfunction

  task automatic setWord(input logic [31:0] a, input logic [31:0] v);
    wordMem[a] = v;
    for (int i = 0; i < 4; i++) refMem[a + 32'(i)] = v[8*i +: 8];
  endtask

  task automatic preload();
    wordMem.delete();
    refMem.delete();
    setWord(32'h0, 32'h12345678);
    setWord(32'h4, 32'hABCDEF00);
  endtask

  // Predict the response and the beats by walking the accessed bytes one at a time.
  task automatic refCompute(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rdata, output bit err);
    int size;
    bit legal;
    logic [31:0] ba, wa, val;
    int lane;
    legal = (ctrl == 3'b000 || ctrl == 3'b001 || ctrl == 3'b010 ||
             (!we && (ctrl == 3'b100 || ctrl == 3'b101)));
    size = (ctrl[1:0] == 2'b00) ? 1 : (ctrl[1:0] == 2'b01) ? 2 : 4;
    err = !legal || ((int'(addr[1:0]) + size > 4) && !SPLIT);
    expCount = 0;
    rdata = 32'h0;
    val = 32'h0;
    if (!err) begin
      for (int i = 0; i < size; i++) begin
        ba = addr + 32'(i);
        wa = ba & 32'hFFFF_FFFC;
        lane = int'(ba % 4);
        if (expCount == 0 || expAddr[expCount-1] != wa) begin
          expAddr[expCount] = wa;
          expBe[expCount]   = 4'h0;
          expWd[expCount]   = 32'h0;
          expCount++;
        end
        expBe[expCount-1][lane] = 1'b1;
        if (we) begin
          expWd[expCount-1][8*lane +: 8] = wdata[8*i +: 8];
          refMem[ba] = wdata[8*i +: 8];
        end else begin
          val[8*i +: 8] = refByte(ba);
        end
      end
      if (!we) begin
        if (ctrl == 3'b000 && val[7])  val = val | 32'hFFFF_FF00;
        if (ctrl == 3'b001 && val[15]) val = val | 32'hFFFF_0000;
        rdata = val;
      end
    end
  endtask

  // Compare logged beats with the predicted ones (write data only in enabled lanes).
  task automatic compareBeats(input string tag, input bit we);
    logic [31:0] laneMask;
    checkOutput({tag, "_nbeats"}, 32'(logAddr.size()), 32'(expCount));
    for (int i = 0; i < expCount && i < logAddr.size(); i++) begin
      checkOutput($sformatf("%s_b%0d_addr", tag, i), logAddr[i], expAddr[i]);
      checkOutput($sformatf("%s_b%0d_be", tag, i), 32'(logBe[i]), 32'(expBe[i]));
      checkOutput($sformatf("%s_b%0d_we", tag, i), 32'(logWe[i]), 32'(we));
      if (we) begin
        laneMask = {{8{expBe[i][3]}}, {8{expBe[i][2]}}, {8{expBe[i][1]}}, {8{expBe[i][0]}}};
        checkOutput($sformatf("%s_b%0d_wdata", tag, i), logWd[i] & laneMask, expWd[i]);
      end
    end
  endtask

  // Present one request, wait for its response and report data, error and latency.
  task automatic applyStimulus(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [31:0] rdata,
                               output bit err, output int lat);
    int w;
    logAddr.delete(); logBe.delete(); logWe.delete(); logWd.delete();
    rdata = 32'h0; err = 1'b0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_ctrl = ctrl; req_addr = addr; req_wdata = wdata;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) begin
      timeoutFail("accept");
      req_valid = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      timeoutFail("response");
      return;
    end
    rdata = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
    checkOutput("rsp_one_cycle", 32'(rsp_valid), 32'h0);
  endtask

  typedef struct {
    bit          we;
    logic [2:0]  ctrl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] expRdata;
    bit          expErr;
    int          expBeats;
    logic [3:0]  expBe0;
    int          expLat;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input bit we, input logic [2:0] ctrl, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] rd, input bit er,
                        input int nb, input logic [3:0] be0, input int lat);
    vec_t v;
    v.we = we; v.ctrl = ctrl; v.addr = addr; v.wdata = wdata; v.expRdata = rd;
    v.expErr = er; v.expBeats = nb; v.expBe0 = be0; v.expLat = lat;
    vecs.push_back(v);
  endtask

  initial begin
    logic [31:0] rd, erd;
    bit er, eer;
    int lat, rspSeen;
    string tag;
    bit we;
    logic [2:0] ctrl;
    logic [31:0] addr, wd;

    // Directed vectors against the preloaded words 0x12345678 / 0xABCDEF00.
    addVec(0, 3'b010, 32'h0, 32'h0, 32'h12345678, 0, 1, 4'b1111, 3);
    addVec(0, 3'b000, 32'h7, 32'h0, 32'hFFFFFFAB, 0, 1, 4'b1000, 3);
    addVec(0, 3'b100, 32'h7, 32'h0, 32'h000000AB, 0, 1, 4'b1000, 3);
    addVec(0, 3'b001, 32'h6, 32'h0, 32'hFFFFABCD, 0, 1, 4'b1100, 3);
    addVec(0, 3'b101, 32'h5, 32'h0, 32'h0000CDEF, 0, 1, 4'b0110, 3);
    if (SPLIT) addVec(0, 3'b010, 32'h3, 32'h0, 32'hCDEF0012, 0, 2, 4'b1000, 5);
    else       addVec(0, 3'b010, 32'h3, 32'h0, 32'h0, 1, 0, 4'b0000, 1);
    addVec(1, 3'b001, 32'h2, 32'h0000BEEF, 32'h0, 0, 1, 4'b1100, 3);
    addVec(0, 3'b010, 32'h0, 32'h0, 32'hBEEF5678, 0, 1, 4'b1111, 3);
    addVec(0, 3'b001, 32'h1, 32'h0, 32'hFFFFEF56, 0, 1, 4'b0110, 3);
    addVec(1, 3'b000, 32'h5, 32'hFFFFFFAA, 32'h0, 0, 1, 4'b0010, 3);
    addVec(0, 3'b010, 32'h4, 32'h0, 32'hABCDAA00, 0, 1, 4'b1111, 3);
    addVec(0, 3'b011, 32'h0, 32'h0, 32'h0, 1, 0, 4'b0000, 1);
    addVec(1, 3'b100, 32'h0, 32'h0, 32'h0, 1, 0, 4'b0000, 1);
    addVec(0, 3'b111, 32'h4, 32'h0, 32'h0, 1, 0, 4'b0000, 1);

    // Reset values while held in reset.
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'h0);
    checkOutput("rst_mem_be", 32'(mem_be), 32'h0);
    checkOutput("rst_mem_addr", mem_addr, 32'h0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'h0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("rst_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("rst_rsp_err", 32'(rsp_err), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("rst_req_ready", 32'(req_ready), 32'h1);

    // Table-driven directed vectors with an always-granting memory.
    preload();
    for (int i = 0; i < vecs.size(); i++) begin
      tag = $sformatf("vec%0d", i);
      refCompute(vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, erd, eer);
      applyStimulus(vecs[i].we, vecs[i].ctrl, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      checkOutput({tag, "_rdata"}, rd, vecs[i].expRdata);
      checkOutput({tag, "_err"}, 32'(er), 32'(vecs[i].expErr));
      checkOutput({tag, "_lat"}, 32'(lat), 32'(vecs[i].expLat));
      checkOutput({tag, "_nbeats"}, 32'(logAddr.size()), 32'(vecs[i].expBeats));
      if (logBe.size() > 0) checkOutput({tag, "_be0"}, 32'(logBe[0]), 32'(vecs[i].expBe0));
      compareBeats({tag, "_ref"}, vecs[i].we);
    end

    // Stalled grant: word store, then split store (or its error).
    preload();
    stallCnt = 3;
    refCompute(1, 3'b010, 32'h4, 32'h11223344, erd, eer);
    applyStimulus(1, 3'b010, 32'h4, 32'h11223344, rd, er, lat);
    checkOutput("stall_sw_lat", 32'(lat), 32'd6);
    compareBeats("stall_sw", 1'b1);
    preload();
    stallCnt = 3;
    refCompute(1, 3'b010, 32'h6, 32'h11223344, erd, eer);
    applyStimulus(1, 3'b010, 32'h6, 32'h11223344, rd, er, lat);
    stallCnt = 0;
    checkOutput("split_sw_err", 32'(er), SPLIT ? 32'h0 : 32'h1);
    if (SPLIT) begin
      checkOutput("split_sw_nbeats", 32'(logAddr.size()), 32'd2);
      if (logAddr.size() == 2) begin
        checkOutput("split_sw_a0", logAddr[0], 32'h4);
        checkOutput("split_sw_be0", 32'(logBe[0]), 32'hC);
        checkOutput("split_sw_wd0", logWd[0], 32'h33440000);
        checkOutput("split_sw_a1", logAddr[1], 32'h8);
        checkOutput("split_sw_be1", 32'(logBe[1]), 32'h3);
        checkOutput("split_sw_wd1", logWd[1], 32'h00001122);
      end
    end else begin
      checkOutput("split_sw_nbeats", 32'(logAddr.size()), 32'd0);
    end
    applyStimulus(0, 3'b010, 32'h4, 32'h0, rd, er, lat);
    checkOutput("split_sw_readback", rd, SPLIT ? 32'h3344EF00 : 32'hABCDEF00);

    // Address wrap at the top of the address space.
    preload();
    setWord(32'hFFFFFFFC, 32'h11223344);
    refCompute(0, 3'b001, 32'hFFFFFFFF, 32'h0, erd, eer);
    applyStimulus(0, 3'b001, 32'hFFFFFFFF, 32'h0, rd, er, lat);
    checkOutput("wrap_err", 32'(er), SPLIT ? 32'h0 : 32'h1);
    checkOutput("wrap_rdata", rd, SPLIT ? 32'h00007811 : 32'h0);
    compareBeats("wrap", 1'b0);
    if (SPLIT && logAddr.size() == 2) checkOutput("wrap_a1", logAddr[1], 32'h0);

    // Reset pulsed while waiting for rvalid; the late rvalid must be ignored.
    preload();
    rvalidDelay = 4;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_ctrl = 3'b010; req_addr = 32'h0;
    @(negedge clk);
    req_valid = 1'b0;
    checkOutput("rstw_req_seen", 32'(mem_req), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstw_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rstw_rsp_valid", 32'(rsp_valid), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    rspSeen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rsp_valid) rspSeen++;
    end
    checkOutput("rstw_no_rsp", 32'(rspSeen), 32'h0);
    checkOutput("rstw_ready", 32'(req_ready), 32'h1);
    rvalidDelay = 1;
    applyStimulus(0, 3'b010, 32'h0, 32'h0, rd, er, lat);
    checkOutput("rstw_recover", rd, 32'h12345678);

    // Randomized traffic with random grant stalls against the byte-level model.
    preload();
    randomGnt = 1'b1;
    for (int n = 0; n < 300; n++) begin
      we = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0, 1:    ctrl = 3'b000;
        2, 3:    ctrl = 3'b001;
        4, 5:    ctrl = 3'b010;
        6:       ctrl = 3'b100;
        7:       ctrl = 3'b101;
        8:       ctrl = 3'b011;
        default: ctrl = 3'b110;
      endcase
      if ($urandom_range(0, 7) == 0) addr = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
      else                           addr = 32'($urandom_range(0, 31));
      wd = $urandom;
      tag = $sformatf("rnd%0d", n);
      refCompute(we, ctrl, addr, wd, erd, eer);
      applyStimulus(we, ctrl, addr, wd, rd, er, lat);
      checkOutput({tag, "_rdata"}, rd, erd);
      checkOutput({tag, "_err"}, 32'(er), 32'(eer));
      compareBeats(tag, we);
    end
    randomGnt = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
